// File: rtl/serial_frame_tx.sv
// serial_frame_tx: LSB-first start/data/stop serializer, each bit held BIT_DIV clocks.
// Define SERIAL_FRAME_TX_PARITY_EN to insert an even-parity bit between data and stop.
module serial_frame_tx #(
    parameter int DATA_W  = 8,
    parameter int BIT_DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              sout,
    output logic              busy,
    output logic              frame_done
);
    localparam int DIV_W = BIT_DIV > 1 ? $clog2(BIT_DIV) : 1;
    localparam int BIT_W = DATA_W > 1 ? $clog2(DATA_W) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BIT_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DATA_W - 1);

`ifdef SERIAL_FRAME_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t            r_state, w_state_n;
    logic [DIV_W-1:0]  r_div, w_div_n;
    logic [BIT_W-1:0]  r_bit, w_bit_n;
    logic [DATA_W-1:0] r_sh, w_sh_n;
    logic              r_sout, r_busy, r_done;
    logic              w_sout_n, w_last, w_accept;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    logic              r_par, w_par_n;
`endif

    assign din_ready  = (r_state == IDLE) && reset;
    assign w_accept   = din_valid && din_ready;
    assign w_last     = r_div == DIV_MAX;
    assign sout       = r_sout;
    assign busy       = r_busy;
    assign frame_done = r_done;

    always_comb begin
        w_state_n = r_state;
        w_div_n   = w_last ? '0 : r_div + 1'b1;
        w_bit_n   = r_bit;
        w_sh_n    = r_sh;
`ifdef SERIAL_FRAME_TX_PARITY_EN
        w_par_n   = r_par;
`endif
        case (r_state)
            IDLE: begin
                w_div_n = '0;
                if (w_accept) begin
                    w_state_n = START;
                    w_sh_n    = din;
                    w_bit_n   = '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                    w_par_n   = ^din;
`endif
                end
            end
            START: if (w_last) w_state_n = DATA;
            DATA: if (w_last) begin
                w_sh_n  = r_sh >> 1;
                w_bit_n = r_bit + 1'b1;
                if (r_bit == BIT_MAX) begin
                    w_bit_n = '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                    w_state_n = PARITY;
`else
                    w_state_n = STOP;
`endif
                end
            end
`ifdef SERIAL_FRAME_TX_PARITY_EN
            PARITY: if (w_last) w_state_n = STOP;
`endif
            STOP: if (w_last) w_state_n = IDLE;
            default: w_state_n = IDLE;
        endcase
        // outputs are registered, so they are decoded from the upcoming state
`ifdef SERIAL_FRAME_TX_PARITY_EN
        w_sout_n = w_state_n == START  ? 1'b0 :
                   w_state_n == DATA   ? w_sh_n[0] :
                   w_state_n == PARITY ? r_par : 1'b1;
`else
        w_sout_n = w_state_n == START ? 1'b0 :
                   w_state_n == DATA  ? w_sh_n[0] : 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_sh    <= '0;
            r_sout  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_n;
            r_div   <= w_div_n;
            r_bit   <= w_bit_n;
            r_sh    <= w_sh_n;
            r_sout  <= w_sout_n;
            r_busy  <= w_state_n != IDLE;
            r_done  <= (w_state_n == STOP) && (w_div_n == DIV_MAX);
`ifdef SERIAL_FRAME_TX_PARITY_EN
            r_par   <= w_par_n;
`endif
        end
    end
endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: checks two framer configurations (8b/div2 and 4b/div1) against a frame-bit model.
module tb_serial_frame_tx;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int LEN_A = (8 + 2 + PAR) * 2;
    localparam int LEN_B = (4 + 2 + PAR) * 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] a_din = '0;
    logic       a_valid = 1'b0;
    logic       a_ready, a_sout, a_busy, a_done;
    logic [3:0] b_din = '0;
    logic       b_valid = 1'b0;
    logic       b_ready, b_sout, b_busy, b_done;
    int         n_pass = 0;
    int         n_total = 0;

    always #5 clk = ~clk;

    serial_frame_tx #(.DATA_W(8), .BIT_DIV(2)) u_a (
        .clk(clk), .reset(reset), .din(a_din), .din_valid(a_valid),
        .din_ready(a_ready), .sout(a_sout), .busy(a_busy), .frame_done(a_done)
    );

    serial_frame_tx #(.DATA_W(4), .BIT_DIV(1)) u_b (
        .clk(clk), .reset(reset), .din(b_din), .din_valid(b_valid),
        .din_ready(b_ready), .sout(b_sout), .busy(b_busy), .frame_done(b_done)
    );

    // frame bit i: start, data LSB first, optional even parity, stop
    function automatic logic [34:0] frame_bits(input logic [31:0] w, input int dw);
        logic [34:0] f = '0;
        logic p = 1'b0;
        for (int i = 0; i < dw; i++) begin
            f[i+1] = w[i];
            p ^= w[i];
        end
        if (PAR == 1) f[dw+1] = p;
        f[dw+1+PAR] = 1'b1;
        return f;
    endfunction

    task automatic test_reset;
        logic [3:0] exp = 4'b1000;
        a_valid = 1'b1; a_din = 8'hA5; b_valid = 1'b1; b_din = 4'hA;
        repeat (2) begin
            @(negedge clk);
            n_total++;
            if ({a_sout, a_busy, a_done, a_ready} !== exp) $display("FAIL reset_a got %b expected %b", {a_sout, a_busy, a_done, a_ready}, exp); else n_pass++;
            n_total++;
            if ({b_sout, b_busy, b_done, b_ready} !== exp) $display("FAIL reset_b got %b expected %b", {b_sout, b_busy, b_done, b_ready}, exp); else n_pass++;
        end
        a_valid = 1'b0; b_valid = 1'b0; reset = 1'b1;
        exp = 4'b1001;
        repeat (2) begin
            @(negedge clk);
            n_total++;
            if ({a_sout, a_busy, a_done, a_ready} !== exp) $display("FAIL idle_a got %b expected %b", {a_sout, a_busy, a_done, a_ready}, exp); else n_pass++;
            n_total++;
            if ({b_sout, b_busy, b_done, b_ready} !== exp) $display("FAIL idle_b got %b expected %b", {b_sout, b_busy, b_done, b_ready}, exp); else n_pass++;
        end
    endtask

    task automatic test_frame_a;
        logic [7:0] words [2] = '{8'hA5, 8'h07};
        logic [34:0] f;
        logic [3:0] exp;
        for (int k = 0; k < 2; k++) begin
            f = frame_bits({24'h0, words[k]}, 8);
            a_din = words[k]; a_valid = 1'b1;
            for (int c = 0; c < LEN_A; c++) begin
                @(negedge clk);
                a_valid = 1'b0; a_din = ~words[k];
                exp = {f[c/2], 1'b1, c == LEN_A - 1, 1'b0};
                n_total++;
                if ({a_sout, a_busy, a_done, a_ready} !== exp) $display("FAIL frame_a w=%h cyc %0d got %b expected %b", words[k], c + 1, {a_sout, a_busy, a_done, a_ready}, exp); else n_pass++;
            end
            @(negedge clk);
            n_total++;
            if ({a_sout, a_busy, a_done, a_ready} !== 4'b1001) $display("FAIL frame_a_end got %b expected 1001", {a_sout, a_busy, a_done, a_ready}); else n_pass++;
        end
    endtask

    task automatic test_minimal;
        logic [34:0] f = frame_bits(32'hA, 4);
        logic [3:0] exp;
        b_din = 4'hA; b_valid = 1'b1;
        for (int c = 0; c < LEN_B; c++) begin
            @(negedge clk);
            b_valid = 1'b0;
            exp = {f[c], 1'b1, c == LEN_B - 1, 1'b0};
            n_total++;
            if ({b_sout, b_busy, b_done, b_ready} !== exp) $display("FAIL minimal cyc %0d got %b expected %b", c + 1, {b_sout, b_busy, b_done, b_ready}, exp); else n_pass++;
        end
        @(negedge clk);
        n_total++;
        if ({b_sout, b_busy, b_done, b_ready} !== 4'b1001) $display("FAIL minimal_end got %b expected 1001", {b_sout, b_busy, b_done, b_ready}); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [34:0] f;
        logic [3:0] exp;
        a_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            a_din = k == 1 ? 8'hFF : 8'h00;
            f = frame_bits({24'h0, a_din}, 8);
            for (int c = 0; c < LEN_A; c++) begin
                @(negedge clk);
                if (k == 1) a_valid = 1'b0;
                exp = {f[c/2], 1'b1, c == LEN_A - 1, 1'b0};
                n_total++;
                if ({a_sout, a_busy, a_done, a_ready} !== exp) $display("FAIL b2b frame %0d cyc %0d got %b expected %b", k, c + 1, {a_sout, a_busy, a_done, a_ready}, exp); else n_pass++;
            end
            @(negedge clk);
            n_total++;
            if ({a_sout, a_busy, a_done, a_ready} !== 4'b1001) $display("FAIL b2b_gap %0d got %b expected 1001", k, {a_sout, a_busy, a_done, a_ready}); else n_pass++;
        end
    endtask

    task automatic test_valid_while_busy;
        logic [34:0] f = frame_bits(32'h81, 8);
        logic [3:0] exp;
        a_din = 8'h81; a_valid = 1'b1;
        for (int c = 0; c < LEN_A; c++) begin
            @(negedge clk);
            a_valid = c == 6;
            a_din = c == 6 ? 8'h3C : 8'h81;
            exp = {f[c/2], 1'b1, c == LEN_A - 1, 1'b0};
            n_total++;
            if ({a_sout, a_busy, a_done, a_ready} !== exp) $display("FAIL busy_valid cyc %0d got %b expected %b", c + 1, {a_sout, a_busy, a_done, a_ready}, exp); else n_pass++;
        end
        repeat (LEN_A) begin
            @(negedge clk);
            n_total++;
            if ({a_sout, a_busy, a_done, a_ready} !== 4'b1001) $display("FAIL busy_valid_idle got %b expected 1001", {a_sout, a_busy, a_done, a_ready}); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [34:0] f = frame_bits(32'hC3, 8);
        logic [3:0] exp;
        a_din = 8'hC3; a_valid = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            a_valid = 1'b0;
            exp = {f[c/2], 1'b1, 1'b0, 1'b0};
            n_total++;
            if ({a_sout, a_busy, a_done, a_ready} !== exp) $display("FAIL rst_pre cyc %0d got %b expected %b", c + 1, {a_sout, a_busy, a_done, a_ready}, exp); else n_pass++;
        end
        reset = 1'b0;
        @(negedge clk);
        n_total++;
        if ({a_sout, a_busy, a_done, a_ready} !== 4'b1000) $display("FAIL rst_mid got %b expected 1000", {a_sout, a_busy, a_done, a_ready}); else n_pass++;
        reset = 1'b1;
        repeat (LEN_A) begin
            @(negedge clk);
            n_total++;
            if ({a_sout, a_busy, a_done, a_ready} !== 4'b1001) $display("FAIL rst_no_resume got %b expected 1001", {a_sout, a_busy, a_done, a_ready}); else n_pass++;
        end
        f = frame_bits(32'h55, 8);
        a_din = 8'h55; a_valid = 1'b1;
        for (int c = 0; c < LEN_A; c++) begin
            @(negedge clk);
            a_valid = 1'b0;
            exp = {f[c/2], 1'b1, c == LEN_A - 1, 1'b0};
            n_total++;
            if ({a_sout, a_busy, a_done, a_ready} !== exp) $display("FAIL rst_post cyc %0d got %b expected %b", c + 1, {a_sout, a_busy, a_done, a_ready}, exp); else n_pass++;
        end
        @(negedge clk);
        n_total++;
        if ({a_sout, a_busy, a_done, a_ready} !== 4'b1001) $display("FAIL rst_post_end got %b expected 1001", {a_sout, a_busy, a_done, a_ready}); else n_pass++;
    endtask

    task automatic test_random;
        logic [34:0] f;
        logic [3:0] exp;
        logic [7:0] w;
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                n_total++;
                if ({a_sout, a_busy, a_done, a_ready, b_sout, b_busy, b_done, b_ready} !== 8'h99) $display("FAIL rand_idle got %b expected 10011001", {a_sout, a_busy, a_done, a_ready, b_sout, b_busy, b_done, b_ready}); else n_pass++;
            end
            w = 8'($urandom);
            if (k % 2 == 0) begin
                f = frame_bits({24'h0, w}, 8);
                a_din = w; a_valid = 1'b1;
                for (int c = 0; c < LEN_A; c++) begin
                    @(negedge clk);
                    a_din = 8'($urandom);
                    a_valid = c < LEN_A - 1 ? 1'($urandom) : 1'b0;
                    exp = {f[c/2], 1'b1, c == LEN_A - 1, 1'b0};
                    n_total++;
                    if ({a_sout, a_busy, a_done, a_ready} !== exp) $display("FAIL rand_a w=%h cyc %0d got %b expected %b", w, c + 1, {a_sout, a_busy, a_done, a_ready}, exp); else n_pass++;
                end
            end else begin
                f = frame_bits({28'h0, w[3:0]}, 4);
                b_din = w[3:0]; b_valid = 1'b1;
                for (int c = 0; c < LEN_B; c++) begin
                    @(negedge clk);
                    b_din = 4'($urandom);
                    b_valid = c < LEN_B - 1 ? 1'($urandom) : 1'b0;
                    exp = {f[c], 1'b1, c == LEN_B - 1, 1'b0};
                    n_total++;
                    if ({b_sout, b_busy, b_done, b_ready} !== exp) $display("FAIL rand_b w=%h cyc %0d got %b expected %b", w[3:0], c + 1, {b_sout, b_busy, b_done, b_ready}, exp); else n_pass++;
                end
            end
            @(negedge clk);
            n_total++;
            if ({a_sout, a_busy, a_done, a_ready, b_sout, b_busy, b_done, b_ready} !== 8'h99) $display("FAIL rand_end got %b expected 10011001", {a_sout, a_busy, a_done, a_ready, b_sout, b_busy, b_done, b_ready}); else n_pass++;
        end
    endtask

    initial begin
        test_reset;
        test_frame_a;
        test_minimal;
        test_back_to_back;
        test_valid_while_busy;
        test_reset_mid_frame;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
